// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the instruction encoder: RV32/RV64 base opcodes
// recognised by the control decoder, request-kind codes, encoder FSM states,
// the FIFO entry layout and small field-packing helpers.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_RW     = 7'b0111011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  typedef enum logic [2:0] {
    KIND_R      = 3'd0,
    KIND_RW     = 3'd1,
    KIND_LOAD   = 3'd2,
    KIND_STORE  = 3'd3,
    KIND_BRANCH = 3'd4,
    KIND_LI     = 3'd5,
    KIND_RSV6   = 3'd6,
    KIND_RSV7   = 3'd7
  } req_kind_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LI2  = 1'b1
  } enc_state_e;

  typedef struct packed {
    logic        last;
    logic [31:0] instr;
  } enc_word_t;

  // True when a 32-bit value is representable as a 12-bit signed immediate.
  function automatic logic fits_simm12(input logic [31:11] v_hi);
    return (v_hi == '0) || (v_hi == '1);
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm12, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm12, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm12, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm12[11:5], rs2, rs1, f3, imm12[4:0], OP_STORE};
  endfunction

  // Branch offsets are even, so bit 0 never reaches the word.
  function automatic logic [31:0] enc_b(input logic [12:1] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm20, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm20, rd, op};
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// instr_enc_fifo
// Synchronous FIFO holding encoded words ({last, instr}) on their way to
// instruction memory. Head is presented combinationally; data reads as zero
// while empty so the output bus is clean after reset.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   wr_en_i/data_i  push request (ignored when full)
//   rd_en_i         pop request (ignored when empty)
//   rd_valid_o      FIFO not empty
//   rd_data_o       head entry
//   level_o         occupied entries
//   full_o          level == DEPTH
module instr_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic                     rd_valid_o,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty  = (level_q == '0);
  assign full_o = (level_q == LW'(DEPTH));
  // Full-ness is judged on the pre-edge level: a simultaneous pop does not
  // make room for a push in the same cycle.
  assign push   = wr_en_i & ~full_o;
  assign pop    = rd_en_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_valid_o = ~empty;
  assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign level_o    = level_q;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
// Assembles 32-bit RV instruction words from field-level requests and streams
// them to the instruction-memory write port through a small FIFO. The LI
// pseudo-op expands to ADDI, LUI, or LUI+ADDI.
// Optional build macro: INSTR_ENC_CHECK_EN adds the enc_err range checker.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready request handshake
//   req_kind..req_imm   request fields (kind, registers, funct3/7, immediate)
//   out_valid/out_ready output handshake (FIFO head)
//   out_instr, out_last encoded word, final word of its request
//   fifo_level          occupied FIFO entries
//   enc_err             (INSTR_ENC_CHECK_EN) one-cycle error pulse after accept
//
// state  | meaning
// S_IDLE | ready for a new request; word 0 written at accept
// S_LI2  | LI needs its trailing ADDI; waiting for a free FIFO slot
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [2:0]                    req_kind,
  input  logic [4:0]                    req_rd,
  input  logic [4:0]                    req_rs1,
  input  logic [4:0]                    req_rs2,
  input  logic [2:0]                    req_funct3,
  input  logic [6:0]                    req_funct7,
  input  logic [31:0]                   req_imm,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instr,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef INSTR_ENC_CHECK_EN
  ,
  output logic                          enc_err
`endif
);

  enc_state_e  state_q, state_d;
  logic [4:0]  li_rd_q, li_rd_d;
  logic [11:0] li_lo_q, li_lo_d;

  logic        accept;
  logic        fifo_full;
  logic        wr_en;
  enc_word_t   wr_word;
  enc_word_t   head;
  logic [19:0] li_hi;

  assign req_ready = (state_q == S_IDLE) & ~fifo_full;
  assign accept    = req_valid & req_ready;

  // (imm + 0x800) >> 12: adding 0x800 carries into bit 12 exactly when
  // imm[11] is set, so the upper part is imm[31:12] + imm[11] (mod 2^20).
  assign li_hi = req_imm[31:12] + {19'd0, req_imm[11]};

  always_comb begin
    state_d       = state_q;
    li_rd_d       = li_rd_q;
    li_lo_d       = li_lo_q;
    wr_en         = 1'b0;
    wr_word.last  = 1'b1;
    wr_word.instr = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (req_kind_e'(req_kind))
            KIND_R: begin
              wr_en         = 1'b1;
              wr_word.instr = enc_r(req_funct7, req_rs2, req_rs1, req_funct3, req_rd, OP_R);
            end
            KIND_RW: begin
              wr_en         = 1'b1;
              wr_word.instr = enc_r(req_funct7, req_rs2, req_rs1, req_funct3, req_rd, OP_RW);
            end
            KIND_LOAD: begin
              wr_en         = 1'b1;
              wr_word.instr = enc_i(req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LOAD);
            end
            KIND_STORE: begin
              wr_en         = 1'b1;
              wr_word.instr = enc_s(req_imm[11:0], req_rs2, req_rs1, req_funct3);
            end
            KIND_BRANCH: begin
              wr_en         = 1'b1;
              wr_word.instr = enc_b(req_imm[12:1], req_rs2, req_rs1, req_funct3);
            end
            KIND_LI: begin
              wr_en = 1'b1;
              if (fits_simm12(req_imm[31:11])) begin
                wr_word.instr = enc_i(req_imm[11:0], 5'd0, 3'b000, req_rd, OP_IMM);
              end else begin
                wr_word.instr = enc_u(li_hi, req_rd, OP_LUI);
                if (req_imm[11:0] != 12'd0) begin
                  wr_word.last = 1'b0;
                  state_d      = S_LI2;
                  li_rd_d      = req_rd;
                  li_lo_d      = req_imm[11:0];
                end
              end
            end
            default: begin
              // Reserved kinds are consumed without producing a word.
              wr_en = 1'b0;
            end
          endcase
        end
      end
      S_LI2: begin
        if (!fifo_full) begin
          wr_en         = 1'b1;
          wr_word.instr = enc_i(li_lo_q, li_rd_q, 3'b000, li_rd_q, OP_IMM);
          state_d       = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      li_rd_q <= '0;
      li_lo_q <= '0;
    end else begin
      state_q <= state_d;
      li_rd_q <= li_rd_d;
      li_lo_q <= li_lo_d;
    end
  end

  instr_enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_word),
    .rd_en_i    (out_ready),
    .rd_valid_o (out_valid),
    .rd_data_o  (head),
    .level_o    (fifo_level),
    .full_o     (fifo_full)
  );

  assign out_instr = head.instr;
  assign out_last  = head.last;

`ifdef INSTR_ENC_CHECK_EN
  logic err_d, err_q;

  always_comb begin
    err_d = 1'b0;
    if (accept) begin
      case (req_kind_e'(req_kind))
        KIND_BRANCH: begin
          err_d = req_imm[0]
                | ($signed(req_imm) < -32'sd4096)
                | ($signed(req_imm) >  32'sd4094);
        end
        KIND_LOAD, KIND_STORE: begin
          err_d = ~fits_simm12(req_imm[31:11]);
        end
        KIND_RSV6, KIND_RSV7: begin
          err_d = 1'b1;
        end
        default: begin
          err_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign enc_err = err_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_kind = '0;
  logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [2:0]  req_funct3 = '0;
  logic [6:0]  req_funct7 = '0;
  logic [31:0] req_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_last;
  logic [2:0]  fifo_level;
`ifdef INSTR_ENC_CHECK_EN
  logic        enc_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q[$];
  logic rand_on = 1'b0;

  always #5 clk = ~clk;

  instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_funct3 (req_funct3),
    .req_funct7 (req_funct7),
    .req_imm    (req_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_last   (out_last),
    .fifo_level (fifo_level)
`ifdef INSTR_ENC_CHECK_EN
    ,
    .enc_err    (enc_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: builds words from the instruction-format definitions
  // using plain arithmetic on field values.
  function automatic void model_push(input int k, input int rd, input int rs1, input int rs2,
                                     input int f3, input int f7, input logic [31:0] imm);
    longint unsigned w, off, lo, hi;
    longint sv;
    sv = longint'($signed(imm));
    case (k)
      0, 1: begin
        w = f7 * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + (k == 0 ? 51 : 59);
        exp_q.push_back({1'b1, w[31:0]});
      end
      2: begin
        w = (imm % 4096) * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 3;
        exp_q.push_back({1'b1, w[31:0]});
      end
      3: begin
        off = imm % 4096;
        w = (off / 32) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + (off % 32) * 2**7 + 35;
        exp_q.push_back({1'b1, w[31:0]});
      end
      4: begin
        off = imm % 8192;
        w = (off / 4096) * 2**31 + ((off / 32) % 64) * 2**25 + rs2 * 2**20 + rs1 * 2**15
          + f3 * 2**12 + ((off / 2) % 16) * 2**8 + ((off / 2048) % 2) * 2**7 + 99;
        exp_q.push_back({1'b1, w[31:0]});
      end
      5: begin
        lo = imm % 4096;
        if (sv >= -2048 && sv <= 2047) begin
          w = lo * 2**20 + rd * 2**7 + 19;
          exp_q.push_back({1'b1, w[31:0]});
        end else begin
          hi = ((longint'(imm) + 2048) / 4096) % (2**20);
          w = hi * 2**12 + rd * 2**7 + 55;
          exp_q.push_back({(lo == 0), w[31:0]});
          if (lo != 0) begin
            w = lo * 2**20 + rd * 2**15 + rd * 2**7 + 19;
            exp_q.push_back({1'b1, w[31:0]});
          end
        end
      end
      default: ;
    endcase
  endfunction

  // Scoreboard: every word taken by the consumer must match the next expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stream_extra: got 0x%08h want no word at %0t", out_instr, $time);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("stream_instr", out_instr, e[31:0]);
        check("stream_last", {31'd0, out_last}, {31'd0, e[32]});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_req(input int k, input int rd, input int rs1, input int rs2,
                          input int f3, input int f7, input logic [31:0] imm,
                          input bit use_model);
    int t;
    req_kind = 3'(k); req_rd = 5'(rd); req_rs1 = 5'(rs1); req_rs2 = 5'(rs2);
    req_funct3 = 3'(f3); req_funct7 = 7'(f7); req_imm = imm;
    req_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_timeout: got req_ready=0 want 1 within 300 cycles");
    end else if (use_model) begin
      model_push(k, rd, rs1, rs2, f3, f7, imm);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_level", {29'd0, fifo_level}, 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int k, rd, rs1, rs2, f3, f7;
    logic [31:0] imm;
    int nw;
    logic [31:0] w0, w1;
    logic l0;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 3, 1, 2, 0, 0,    32'd0,        1, 32'h002081B3, 32'h0, 1'b1};
    vecs[1]  = '{2, 5, 2, 0, 2, 0,    32'd8,        1, 32'h00812283, 32'h0, 1'b1};
    vecs[2]  = '{4, 0, 1, 2, 0, 0,    -32'sd4,      1, 32'hFE208EE3, 32'h0, 1'b1};
    vecs[3]  = '{5, 10, 0, 0, 0, 0,   32'h12345678, 2, 32'h12345537, 32'h67850513, 1'b0};
    vecs[4]  = '{5, 1, 0, 0, 0, 0,    -32'sd5,      1, 32'hFFB00093, 32'h0, 1'b1};
    vecs[5]  = '{5, 1, 0, 0, 0, 0,    32'h00001000, 1, 32'h000010B7, 32'h0, 1'b1};
    vecs[6]  = '{3, 0, 2, 5, 2, 0,    32'd12,       1, 32'h00512623, 32'h0, 1'b1};
    vecs[7]  = '{1, 7, 8, 9, 0, 32,   32'd0,        1, 32'h409403BB, 32'h0, 1'b1};
    vecs[8]  = '{5, 2, 0, 0, 0, 0,    32'd2047,     1, 32'h7FF00113, 32'h0, 1'b1};
    vecs[9]  = '{5, 2, 0, 0, 0, 0,    32'd2048,     2, 32'h00001137, 32'h80010113, 1'b0};
    vecs[10] = '{5, 3, 0, 0, 0, 0,    -32'sd2048,   1, 32'h80000193, 32'h0, 1'b1};
    vecs[11] = '{5, 3, 0, 0, 0, 0,    -32'sd2049,   2, 32'hFFFFF1B7, 32'h7FF18193, 1'b0};
    vecs[12] = '{5, 4, 0, 0, 0, 0,    32'h7FFFF800, 2, 32'h80000237, 32'h80020213, 1'b0};
    vecs[13] = '{4, 0, 1, 2, 1, 0,    32'd4094,     1, 32'h7E209FE3, 32'h0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_level", {29'd0, fifo_level}, 0);
    check("rst_instr", out_instr, 0);
    check("rst_last", {31'd0, out_last}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 1);
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Directed vectors with latency check on the first word
    foreach (vecs[i]) begin
      send_req(vecs[i].k, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7,
               vecs[i].imm, 1'b0);
      exp_q.push_back({vecs[i].l0, vecs[i].w0});
      if (vecs[i].nw == 2) exp_q.push_back({1'b1, vecs[i].w1});
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 1);
      check($sformatf("vec%0d_w0", i), out_instr, vecs[i].w0);
      check($sformatf("vec%0d_last", i), {31'd0, out_last}, {31'd0, vecs[i].l0});
      if (vecs[i].nw == 2) check($sformatf("vec%0d_li2_ready", i), {31'd0, req_ready}, 0);
      drain();
    end

    // Reserved kind: accepted, nothing written, stays idle
    send_req(6, 1, 1, 1, 0, 0, 32'd0, 1'b1);
    @(negedge clk);
    check("rsv_valid", {31'd0, out_valid}, 0);
    check("rsv_level", {29'd0, fifo_level}, 0);
    check("rsv_ready", {31'd0, req_ready}, 1);
    @(posedge clk);
    #1;

    // Full FIFO, LI stalls in S_LI2 with one free slot
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_req(0, i + 1, i + 2, i + 3, i, 0, 32'd0, 1'b1);
    @(negedge clk);
    check("full_level", {29'd0, fifo_level}, 4);
    check("full_ready", {31'd0, req_ready}, 0);
    begin
      logic [31:0] held;
      held = out_instr;
      repeat (2) @(negedge clk);
      check("hold_instr", out_instr, held);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    send_req(5, 10, 0, 0, 0, 0, 32'h12345678, 1'b1);
    @(negedge clk);
    check("li_stall_level", {29'd0, fifo_level}, 4);
    check("li_stall_ready", {31'd0, req_ready}, 0);
    repeat (2) @(negedge clk);
    check("li_stall_level2", {29'd0, fifo_level}, 4);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Reset while in S_LI2 with level 3
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_req(1, i + 5, i, i, 0, 1, 32'd0, 1'b1);
    send_req(5, 7, 0, 0, 0, 0, 32'hDEADBEEF, 1'b1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("pre_rst_level", {29'd0, fifo_level}, 3);
    check("pre_rst_ready", {31'd0, req_ready}, 0);
    @(negedge clk);
    check("mid_rst_level", {29'd0, fifo_level}, 0);
    check("mid_rst_valid", {31'd0, out_valid}, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 1);
    check("post_rst_valid", {31'd0, out_valid}, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

`ifdef INSTR_ENC_CHECK_EN
    send_req(4, 0, 1, 2, 0, 0, 32'd3, 1'b1);
    @(negedge clk);
    check("err_beq_odd", {31'd0, enc_err}, 1);
    @(negedge clk);
    check("err_pulse_end", {31'd0, enc_err}, 0);
    @(posedge clk);
    #1;
    send_req(4, 0, 1, 2, 0, 0, 32'd4094, 1'b1);
    @(negedge clk);
    check("err_beq_ok", {31'd0, enc_err}, 0);
    @(posedge clk);
    #1;
    send_req(2, 1, 1, 0, 2, 0, 32'd2048, 1'b1);
    @(negedge clk);
    check("err_load_range", {31'd0, enc_err}, 1);
    @(posedge clk);
    #1;
    send_req(7, 0, 0, 0, 0, 0, 32'd0, 1'b1);
    @(negedge clk);
    check("err_rsv", {31'd0, enc_err}, 1);
    @(posedge clk);
    #1;
    drain();
`endif

    // Randomized traffic with random backpressure
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int n = 0; n < 300; n++) begin
      int k;
      logic [31:0] imm;
      k = $urandom_range(0, 7);
      case ($urandom_range(0, 4))
        0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1: imm = $urandom();
        2: imm = $urandom() & 32'hFFFFF000;
        3: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        default: imm = 32'h7FFFF800 + 32'($urandom_range(0, 4095));
      endcase
      send_req(k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 7), $urandom_range(0, 127), imm, 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rand_on = 1'b0;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
